// File: rtl/seq_mult_div.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide, WIDTH iterations per op.
// Define SEQ_MULT_DIV_UNSIGNED_EN to honour op_unsigned (MULTU/DIVU); otherwise all ops are signed.
`timescale 1ns/1ps
module seq_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             op_unsigned,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH+1:0] acc;
    logic [WIDTH-1:0] mq;
    logic             q_m1;
    logic [WIDTH+1:0] mcand;
    logic             fix;
    logic             neg_r;

    logic             use_unsigned;
`ifdef SEQ_MULT_DIV_UNSIGNED_EN
    assign use_unsigned = op_unsigned;
`else
    logic unused_op_unsigned;
    assign unused_op_unsigned = op_unsigned;
    assign use_unsigned = 1'b0;
`endif

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] mcand_ext;
    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        a_neg     = ~use_unsigned & a_in[WIDTH-1];
        b_neg     = ~use_unsigned & b_in[WIDTH-1];
        a_mag     = a_neg ? (~a_in + 1'b1) : a_in;
        b_mag     = b_neg ? (~b_in + 1'b1) : b_in;
        mcand_ext = use_unsigned ? {2'b00, a_in} : {{2{a_in[WIDTH-1]}}, a_in};
        case ({mq[0], q_m1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        // Partial remainder stays below 2*divisor, so diff[WIDTH] is a clean borrow flag.
        shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
        diff    = shifted - {1'b0, mcand[WIDTH-1:0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            acc         <= '0;
            mq          <= '0;
            q_m1        <= 1'b0;
            mcand       <= '0;
            fix         <= 1'b0;
            neg_r       <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        counter     <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        acc         <= '0;
                        q_m1        <= 1'b0;
                        if (op && (b_in == '0)) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else if (op) begin
                            state <= DIV;
                            mq    <= a_mag;
                            mcand <= {2'b00, b_mag};
                            fix   <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end else begin
                            state <= MULT;
                            mq    <= b_in;
                            mcand <= mcand_ext;
                            // Booth treats b as signed; an unsigned b with its MSB set needs a<<WIDTH added back.
                            fix   <= use_unsigned & b_in[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                        acc     <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
                        mq      <= {booth_sum[0], mq[WIDTH-1:1]};
                        q_m1    <= mq[0];
                    end else begin
                        hi_out <= acc[WIDTH-1:0] + (fix ? mcand[WIDTH-1:0] : '0);
                        lo_out <= mq;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DIV: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                        acc     <= diff[WIDTH] ? {2'b00, shifted[WIDTH-1:0]} : {2'b00, diff[WIDTH-1:0]};
                        mq      <= {mq[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        lo_out <= fix   ? (~mq + 1'b1) : mq;
                        hi_out <= neg_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_div.sv
// Directed bench for seq_mult_div: signed MULT/DIV results, latency, divide-by-zero, busy/start and reset rules.
`timescale 1ns/1ps
module tb_seq_mult_div;
    logic        clock = 1'b0;
    logic        reset, start, op, op_unsigned;
    logic [31:0] a_in, b_in;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_by_zero;

    int tests  = 0;
    int failed = 0;
    int cycles;
    int done_seen;

    seq_mult_div #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .op_unsigned(op_unsigned),
        .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one start, then scrambles operands; optionally re-pulses start (as a DIV by zero) at cycle 'inject'.
    task automatic run_op(input logic o, input logic u, input logic [31:0] a, input logic [31:0] b,
                          input int inject, output int n);
        op = o; op_unsigned = u; a_in = a; b_in = b; start = 1'b1;
        tick();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        op = 1'b1; op_unsigned = 1'b0; a_in = 32'd5; b_in = 32'd0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            start = (n == inject);
            tick();
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; op_unsigned = 1'b0; a_in = '0; b_in = '0;
        tick(); tick();
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy_done_dbz", {29'd0, busy, done, div_by_zero}, 32'd0);
        reset = 1'b0;
        tick();

        run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, cycles);
        check("mult_7_m3_latency", cycles, 32'd33);
        check("mult_7_m3_hi", hi_out, 32'hFFFF_FFFF);
        check("mult_7_m3_lo", lo_out, 32'hFFFF_FFEB);
        check("mult_7_m3_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();
        check("mult_7_m3_after", {30'd0, busy, done}, 32'd0);

        run_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, cycles);
        check("mult_max_hi", hi_out, 32'h3FFF_FFFF);
        check("mult_max_lo", lo_out, 32'h0000_0001);
        tick();

        run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, cycles);
        check("mult_min_hi", hi_out, 32'h4000_0000);
        check("mult_min_lo", lo_out, 32'h0000_0000);
        tick();

        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, -1, cycles);
        check("div_m7_2_latency", cycles, 32'd33);
        check("div_m7_2_lo", lo_out, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi_out, 32'hFFFF_FFFF);
        check("div_m7_2_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, -1, cycles);
        check("div_7_m2_lo", lo_out, 32'hFFFF_FFFD);
        check("div_7_m2_hi", hi_out, 32'h0000_0001);
        tick();

        run_op(1'b1, 1'b0, 32'd5, 32'd0, -1, cycles);
        check("dbz_latency", cycles, 32'd0);
        check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
        check("dbz_hi_kept", hi_out, 32'h0000_0001);
        check("dbz_lo_kept", lo_out, 32'hFFFF_FFFD);
        tick();
        check("dbz_after", {29'd0, busy, done, div_by_zero}, 32'd1);

        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 10, cycles);
        check("div_wrap_latency", cycles, 32'd33);
        check("div_wrap_lo", lo_out, 32'h8000_0000);
        check("div_wrap_hi", hi_out, 32'h0000_0000);
        check("div_wrap_dbz_cleared", {31'd0, div_by_zero}, 32'd0);
        tick();

        run_op(1'b0, 1'b0, 32'd3, 32'd4, -1, cycles);
        check("mult_3_4_lo", lo_out, 32'd12);
        op = 1'b1; a_in = 32'd9; b_in = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_busy", {30'd0, busy, done}, 32'd0);
        tick();
        check("start_in_done_ignored", {29'd0, busy, done, div_by_zero}, 32'd0);

`ifdef SEQ_MULT_DIV_UNSIGNED_EN
        run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, -1, cycles);
        check("multu_hi", hi_out, 32'h0000_0001);
        check("multu_lo", lo_out, 32'hFFFF_FFFE);
`else
        run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, -1, cycles);
        check("mult_uns_ignored_hi", hi_out, 32'hFFFF_FFFF);
        check("mult_uns_ignored_lo", lo_out, 32'hFFFF_FFFE);
`endif
        tick();

        op = 1'b0; a_in = 32'd5; b_in = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midop_rst_hi", hi_out, 32'd0);
        check("midop_rst_lo", lo_out, 32'd0);
        check("midop_rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("midop_rst_no_done", done_seen, 32'd0);

        op = 1'b1; a_in = 32'd5; b_in = 32'd0; start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        check("rst_beats_start", {29'd0, busy, done, div_by_zero}, 32'd0);
        tick();
        check("rst_beats_start_idle", {29'd0, busy, done, div_by_zero}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
